wisc_run_controller: RTL and testbench
======================================

Name: wisc_run_controller

Overview:
- Synthesisable run controller for one or more WISC-S15 cores.
- Stretches the system reset into a per-core reset and counts run cycles.
- Detects halt (any core or all cores), allows a post-halt drain window, and enforces a cycle-budget watchdog.
- Sits between the board/bench reset and the core array; exposes done/timeout/status so benches and FPGA wrappers no longer hand-code reset sequencing and timeouts.

Parameters:
NUM_CORES, 1, number of core halt inputs monitored
RST_CYCLES, 1, cycles core_rst is held after rst releases; must be >=1
MAX_CYCLES, 100, watchdog budget in RUN cycles; 0 disables the watchdog
DRAIN_CYCLES, 0, cycles spent in DRAIN after the halt condition before DONE
HALT_ALL, 0, 1 = every core must halt; 0 = any core halting suffices
CNT_W, 32, width of cycle_count

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
core_hlt  in  NUM_CORES  per-core halt flag, level
core_rst  out  1  active-high reset to the cores
running  out  1  high in RUN and DRAIN
done  out  1  sticky; halt condition met and drain complete
timeout  out  1  sticky; watchdog expired
halt_mask  out  NUM_CORES  sticky record of cores that have asserted core_hlt
cycle_count  out  CNT_W  RUN cycles elapsed, saturating

Behaviour:
- States: HOLD, RUN, DRAIN, DONE, TOUT.
- Reset (rst==0 at a rising edge):
  - state=HOLD, hold_cnt=0, drain_cnt=0.
  - core_rst=1, running=0, done=0, timeout=0, halt_mask=0, cycle_count=0.
  - Reset applied in any state aborts immediately to these values.
- HOLD (rst==1):
  - hold_cnt increments each edge.
  - On the edge where hold_cnt==RST_CYCLES-1: go to RUN and set core_rst=0.
  - core_rst is therefore high for exactly RST_CYCLES edges after rst is first sampled high.
- RUN:
  - cycle_count+1 each edge; saturates at all-ones, no wrap.
  - halt_mask |= core_hlt.
  - Halt condition uses hm_next = halt_mask|core_hlt:
    - HALT_ALL=1: hm_next all ones.
    - HALT_ALL=0: hm_next nonzero.
  - Halt condition true:
    - DRAIN_CYCLES>0: go to DRAIN, drain_cnt=0.
    - DRAIN_CYCLES==0: go directly to DONE, done=1.
  - Watchdog: when MAX_CYCLES!=0, the halt condition is false, and the post-increment cycle_count == MAX_CYCLES, go to TOUT and set timeout=1.
  - Halt and watchdog on the same edge: halt wins.
- DRAIN:
  - cycle_count frozen at its value on the halt edge.
  - halt_mask keeps accumulating.
  - drain_cnt increments; on the edge where drain_cnt==DRAIN_CYCLES-1, go to DONE and set done=1.
  - Watchdog is inactive.
- DONE / TOUT:
  - Terminal until reset.
  - All outputs frozen; core_rst stays 0 so core state remains inspectable.
  - running=0.
- done and timeout are never both 1.
- core_hlt is ignored in HOLD.
- All outputs are registered; no combinational input-to-output paths.
- Illegal parameters (RST_CYCLES==0, NUM_CORES==0, CNT_W < $clog2(MAX_CYCLES+1)) are caught by an elaboration-time check.

Decomposition:
- Shared package wisc_pkg holds:
  - the run-state enum (HOLD/RUN/DRAIN/DONE/TOUT, 3-bit encoding);
  - the default timing constants (RST_CYCLES_DEF, MAX_CYCLES_DEF).
  The top-level bench and FPGA wrapper use the same values from there.
- One sub-module: wisc_sat_counter.
  - Parameterised width; enable and clear inputs; saturating output.
  - Instantiated for cycle_count; also used for hold_cnt and drain_cnt.

Test Plan:
1. Basic run: NUM_CORES=1, RST_CYCLES=1. Release rst, then raise core_hlt on the 10th RUN cycle. Expect:
   - core_rst falls after 1 edge;
   - done=1 one edge after hlt is sampled;
   - cycle_count=10, timeout=0.
2. Watchdog: MAX_CYCLES=100, core_hlt held 0. Expect:
   - timeout=1 on the edge where cycle_count reaches 100, which is the 100th RUN edge;
   - done=0 and running=0 thereafter.
3. Halt/watchdog collision: MAX_CYCLES=20, core_hlt raised so it is sampled on RUN edge 20. Expect done=1, timeout=0, cycle_count=20.
4. Multi-core all-halt: NUM_CORES=4, HALT_ALL=1, DRAIN_CYCLES=3. Pulse core_hlt bits 0, 2, 1, 3 one cycle each at RUN cycles 5, 8, 11, 14. Expect:
   - halt_mask=4'b1111;
   - DRAIN entered at cycle 14, cycle_count frozen at 14;
   - done=1 after 3 further edges.
5. Stretch plus mid-run reset: RST_CYCLES=4. Expect core_rst high for exactly 4 edges after release. Then drop rst at RUN cycle 7; expect on the next edge:
   - core_rst=1, cycle_count=0, halt_mask=0, state HOLD;
   - on re-release, another 4-edge hold.
6. Saturation: CNT_W=4, MAX_CYCLES=0, no halt. Expect cycle_count to stick at 4'hF with running still 1 and no timeout.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared run-controller definitions for WISC-S15 core arrays: the run-state
// encoding and the default reset-stretch / watchdog timing used by benches and wrappers.
package wisc_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        TOUT  = 3'd4
    } run_state_t;

    localparam int RST_CYCLES_DEF = 1;
    localparam int MAX_CYCLES_DEF = 100;

endpackage

// File: rtl/wisc_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear beats enable.
module wisc_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (i_clr) begin
            w_next = '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            w_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/wisc_run_controller.sv
// Run controller: stretches reset into a per-core reset, counts RUN cycles,
// detects halt (any/all cores), optionally drains, and enforces a cycle watchdog.
module wisc_run_controller
    import wisc_pkg::*;
#(
    parameter int NUM_CORES    = 1,
    parameter int RST_CYCLES   = RST_CYCLES_DEF,
    parameter int MAX_CYCLES   = MAX_CYCLES_DEF,
    parameter int DRAIN_CYCLES = 0,
    parameter int HALT_ALL     = 0,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] core_hlt,
    output logic                 core_rst,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [NUM_CORES-1:0] halt_mask,
    output logic [CNT_W-1:0]     cycle_count
);

    localparam int HOLD_W  = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);
    localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    // Watchdog fires when the count is about to become MAX_CYCLES; the width
    // check guarantees that increment never saturates.
    localparam logic [CNT_W-1:0]   WD_LAST    = CNT_W'(MAX_CYCLES - 1);

    generate
        if (RST_CYCLES < 1 || NUM_CORES < 1 || CNT_W < $clog2(MAX_CYCLES + 1)) begin : g_bad_params
            $error("wisc_run_controller: illegal parameters (RST_CYCLES>=1, NUM_CORES>=1, CNT_W wide enough for MAX_CYCLES)");
        end
    endgenerate

    run_state_t           r_state;
    logic                 r_core_rst;
    logic                 r_running;
    logic                 r_done;
    logic                 r_timeout;
    logic [NUM_CORES-1:0] r_halt_mask;

    logic [HOLD_W-1:0]    w_hold_cnt;
    logic [DRAIN_W-1:0]   w_drain_cnt;
    logic [CNT_W-1:0]     w_cycle_cnt;
    logic [NUM_CORES-1:0] w_hm_next;
    logic                 w_halt;
    logic                 w_watchdog;
    logic                 w_hold_last;
    logic                 w_drain_last;

    wisc_sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_en    (r_state == HOLD),
        .o_count (w_hold_cnt)
    );

    wisc_sat_counter #(.WIDTH(DRAIN_W)) u_drain_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (r_state == RUN),
        .i_en    (r_state == DRAIN),
        .o_count (w_drain_cnt)
    );

    wisc_sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_en    (r_state == RUN),
        .o_count (w_cycle_cnt)
    );

    assign w_hm_next    = r_halt_mask | core_hlt;
    assign w_halt       = (HALT_ALL != 0) ? (&w_hm_next) : (|w_hm_next);
    assign w_watchdog   = (MAX_CYCLES != 0) && (w_cycle_cnt == WD_LAST);
    assign w_hold_last  = (w_hold_cnt == HOLD_LAST);
    assign w_drain_last = (w_drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= HOLD;
            r_core_rst  <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_halt_mask <= '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_hold_last) begin
                        r_state    <= RUN;
                        r_core_rst <= 1'b0;
                        r_running  <= 1'b1;
                    end
                end
                RUN: begin
                    r_halt_mask <= w_hm_next;
                    // Halt is checked first so it wins a same-edge collision with the watchdog.
                    if (w_halt) begin
                        if (DRAIN_CYCLES > 0) begin
                            r_state <= DRAIN;
                        end else begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_running <= 1'b0;
                        end
                    end else if (w_watchdog) begin
                        r_state   <= TOUT;
                        r_timeout <= 1'b1;
                        r_running <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_halt_mask <= w_hm_next;
                    if (w_drain_last) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign core_rst    = r_core_rst;
    assign running     = r_running;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign halt_mask   = r_halt_mask;
    assign cycle_count = w_cycle_cnt;

endmodule

// File: tb/tb_wisc_run_controller.sv
// Bench for wisc_run_controller: five parameterisations stepped in lockstep against
// an edge-counting reference model, directed scenarios followed by random traffic.
module tb_wisc_run_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance configs: 0=A basic, 1=B MAX 20, 2=C 4-core all-halt drain 3, 3=D stretch 4, 4=E 4-bit no watchdog
    int p_rst   [5] = '{1, 1, 1, 4, 1};
    int p_max   [5] = '{100, 20, 100, 100, 0};
    int p_drain [5] = '{0, 0, 3, 0, 0};
    int p_all   [5] = '{0, 0, 1, 0, 0};
    int p_n     [5] = '{1, 1, 4, 1, 1};
    int p_w     [5] = '{32, 32, 32, 32, 4};

    logic       rst_v     [5];
    logic [3:0] hlt_v     [5];
    logic       core_rst_o[5];
    logic       running_o [5];
    logic       done_o    [5];
    logic       tout_o    [5];

    logic [0:0]  hm_a, hm_b, hm_d, hm_e;
    logic [3:0]  hm_c;
    logic [31:0] cc_a, cc_b, cc_c, cc_d;
    logic [3:0]  cc_e;
    logic [3:0]  got_mask[5];
    logic [31:0] got_cc  [5];

    always_comb begin
        got_mask[0] = {3'b000, hm_a};
        got_mask[1] = {3'b000, hm_b};
        got_mask[2] = hm_c;
        got_mask[3] = {3'b000, hm_d};
        got_mask[4] = {3'b000, hm_e};
        got_cc[0]   = cc_a;
        got_cc[1]   = cc_b;
        got_cc[2]   = cc_c;
        got_cc[3]   = cc_d;
        got_cc[4]   = {28'd0, cc_e};
    end

    wisc_run_controller #(.NUM_CORES(1), .RST_CYCLES(1), .MAX_CYCLES(100), .DRAIN_CYCLES(0), .HALT_ALL(0), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst_v[0]), .core_hlt(hlt_v[0][0:0]), .core_rst(core_rst_o[0]), .running(running_o[0]),
        .done(done_o[0]), .timeout(tout_o[0]), .halt_mask(hm_a), .cycle_count(cc_a));
    wisc_run_controller #(.NUM_CORES(1), .RST_CYCLES(1), .MAX_CYCLES(20), .DRAIN_CYCLES(0), .HALT_ALL(0), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst_v[1]), .core_hlt(hlt_v[1][0:0]), .core_rst(core_rst_o[1]), .running(running_o[1]),
        .done(done_o[1]), .timeout(tout_o[1]), .halt_mask(hm_b), .cycle_count(cc_b));
    wisc_run_controller #(.NUM_CORES(4), .RST_CYCLES(1), .MAX_CYCLES(100), .DRAIN_CYCLES(3), .HALT_ALL(1), .CNT_W(32)) u_c (
        .clk(clk), .rst(rst_v[2]), .core_hlt(hlt_v[2]), .core_rst(core_rst_o[2]), .running(running_o[2]),
        .done(done_o[2]), .timeout(tout_o[2]), .halt_mask(hm_c), .cycle_count(cc_c));
    wisc_run_controller #(.NUM_CORES(1), .RST_CYCLES(4), .MAX_CYCLES(100), .DRAIN_CYCLES(0), .HALT_ALL(0), .CNT_W(32)) u_d (
        .clk(clk), .rst(rst_v[3]), .core_hlt(hlt_v[3][0:0]), .core_rst(core_rst_o[3]), .running(running_o[3]),
        .done(done_o[3]), .timeout(tout_o[3]), .halt_mask(hm_d), .cycle_count(cc_d));
    wisc_run_controller #(.NUM_CORES(1), .RST_CYCLES(1), .MAX_CYCLES(0), .DRAIN_CYCLES(0), .HALT_ALL(0), .CNT_W(4)) u_e (
        .clk(clk), .rst(rst_v[4]), .core_hlt(hlt_v[4][0:0]), .core_rst(core_rst_o[4]), .running(running_o[4]),
        .done(done_o[4]), .timeout(tout_o[4]), .halt_mask(hm_e), .cycle_count(cc_e));

    // Reference model: edges since release, total RUN edges, remaining drain edges.
    bit         m_valid [5];
    int         m_rel   [5];
    int         m_run   [5];
    int         m_drain [5];
    bit         m_halted[5];
    bit         m_done  [5];
    bit         m_tout  [5];
    logic [3:0] m_mask  [5];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input int k);
        logic [3:0] full;
        logic [3:0] hv;
        bit         hit;
        full = 4'((5'd1 << p_n[k]) - 5'd1);
        hv   = hlt_v[k] & full;
        if (!rst_v[k]) begin
            m_valid[k] = 1'b1;
            m_rel[k] = 0; m_run[k] = 0; m_drain[k] = 0;
            m_halted[k] = 1'b0; m_done[k] = 1'b0; m_tout[k] = 1'b0;
            m_mask[k] = 4'd0;
        end else begin
            m_rel[k]++;
            if (m_rel[k] > p_rst[k] && !m_done[k] && !m_tout[k]) begin
                m_mask[k] = m_mask[k] | hv;
                if (m_halted[k]) begin
                    m_drain[k]--;
                    if (m_drain[k] == 0) m_done[k] = 1'b1;
                end else begin
                    m_run[k]++;
                    hit = (p_all[k] != 0) ? (m_mask[k] == full) : (m_mask[k] != 4'd0);
                    if (hit) begin
                        m_halted[k] = 1'b1;
                        if (p_drain[k] == 0) m_done[k] = 1'b1;
                        else m_drain[k] = p_drain[k];
                    end else if (p_max[k] != 0 && m_run[k] == p_max[k]) begin
                        m_tout[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_inst(input int k);
        logic [31:0] maxv;
        logic [31:0] ecc;
        if (!m_valid[k]) return;
        maxv = (p_w[k] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << p_w[k]) - 32'd1);
        ecc  = (32'(m_run[k]) > maxv) ? maxv : 32'(m_run[k]);
        chk($sformatf("core_rst[%0d]", k), 32'(core_rst_o[k]), 32'(m_rel[k] < p_rst[k]));
        chk($sformatf("running[%0d]", k), 32'(running_o[k]),
            32'((m_rel[k] >= p_rst[k]) && !m_done[k] && !m_tout[k]));
        chk($sformatf("done[%0d]", k), 32'(done_o[k]), 32'(m_done[k]));
        chk($sformatf("timeout[%0d]", k), 32'(tout_o[k]), 32'(m_tout[k]));
        chk($sformatf("halt_mask[%0d]", k), 32'(got_mask[k]), 32'(m_mask[k]));
        chk($sformatf("cycle_count[%0d]", k), got_cc[k], ecc);
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 5; k++) model_step(k);
        #1;
        for (int k = 0; k < 5; k++) check_inst(k);
    endtask

    task automatic reset_all();
        for (int k = 0; k < 5; k++) begin
            rst_v[k] = 1'b0;
            hlt_v[k] = 4'd0;
        end
        tick();
        tick();
        for (int k = 0; k < 5; k++) rst_v[k] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 5; k++) begin
            rst_v[k] = 1'b0;
            hlt_v[k] = 4'd0;
            m_valid[k] = 1'b0;
        end

        // Basic run: halt sampled on RUN edge 10 (edge 11 after release)
        reset_all();
        chk("reset_core_rst", 32'(core_rst_o[0]), 32'd1);
        chk("reset_cycle_count", cc_a, 32'd0);
        for (int e = 1; e <= 15; e++) begin
            hlt_v[0] = (e == 11) ? 4'd1 : 4'd0;
            tick();
            if (e == 1) chk("basic_core_rst_fall", 32'(core_rst_o[0]), 32'd0);
        end
        hlt_v[0] = 4'd0;
        chk("basic_done", 32'(done_o[0]), 32'd1);
        chk("basic_cycle_count", cc_a, 32'd10);
        chk("basic_timeout", 32'(tout_o[0]), 32'd0);

        // Watchdog on every instance with no halt; 4-bit counter saturates
        reset_all();
        for (int e = 1; e <= 110; e++) begin
            tick();
            if (e == 100) chk("wd_not_yet", 32'(tout_o[0]), 32'd0);
            if (e == 101) chk("wd_fires", 32'(tout_o[0]), 32'd1);
        end
        chk("wd_cycle_count", cc_a, 32'd100);
        chk("wd_done", 32'(done_o[0]), 32'd0);
        chk("wd_running", 32'(running_o[0]), 32'd0);
        chk("sat_cycle_count", {28'd0, cc_e}, 32'hF);
        chk("sat_running", 32'(running_o[4]), 32'd1);
        chk("sat_timeout", 32'(tout_o[4]), 32'd0);

        // Halt and watchdog on the same RUN edge (20)
        reset_all();
        for (int e = 1; e <= 25; e++) begin
            hlt_v[1] = (e == 21) ? 4'd1 : 4'd0;
            tick();
        end
        hlt_v[1] = 4'd0;
        chk("collide_done", 32'(done_o[1]), 32'd1);
        chk("collide_timeout", 32'(tout_o[1]), 32'd0);
        chk("collide_cycle_count", cc_b, 32'd20);

        // All-halt with drain: bits 0,2,1,3 at RUN cycles 5,8,11,14
        reset_all();
        for (int e = 1; e <= 20; e++) begin
            case (e)
                6:       hlt_v[2] = 4'b0001;
                9:       hlt_v[2] = 4'b0100;
                12:      hlt_v[2] = 4'b0010;
                15:      hlt_v[2] = 4'b1000;
                default: hlt_v[2] = 4'b0000;
            endcase
            tick();
            if (e == 17) chk("drain_not_done", 32'(done_o[2]), 32'd0);
            if (e == 18) chk("drain_done", 32'(done_o[2]), 32'd1);
        end
        chk("allhalt_mask", 32'(hm_c), 32'hF);
        chk("allhalt_cycle_count", cc_c, 32'd14);

        // Stretched reset, then mid-run reset at RUN cycle 7 and re-release
        reset_all();
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 3) chk("stretch_still_high", 32'(core_rst_o[3]), 32'd1);
            if (e == 4) chk("stretch_released", 32'(core_rst_o[3]), 32'd0);
        end
        chk("midrun_count", cc_d, 32'd7);
        rst_v[3] = 1'b0;
        tick();
        chk("abort_core_rst", 32'(core_rst_o[3]), 32'd1);
        chk("abort_cycle_count", cc_d, 32'd0);
        chk("abort_running", 32'(running_o[3]), 32'd0);
        rst_v[3] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 3) chk("rehold_still_high", 32'(core_rst_o[3]), 32'd1);
            if (e == 4) chk("rehold_released", 32'(core_rst_o[3]), 32'd0);
        end

        // Random traffic: sporadic resets and halt pulses on every instance
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 5; k++) begin
                rst_v[k] = ($urandom_range(63) != 0);
                for (int b = 0; b < 4; b++)
                    hlt_v[k][b] = (k == 2) ? ($urandom_range(7) == 0) : ($urandom_range(40) == 0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
